// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared types and constants for the sound-effect sequencer
package sfx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_READ  = 2'd2,
    ST_LATCH = 2'd3
  } sfx_state_t;

  typedef logic [1:0] sfx_id_t;

  localparam int          ADDR_W       = 19;
  localparam logic [7:0]  SILENCE      = 8'h80;
  localparam int          LEN0_DEFAULT = 17646;
  localparam int          LEN1_DEFAULT = 12000;
  localparam int          LEN2_DEFAULT = 9000;

endpackage

// File: rtl/sfx_prio_enc.sv
// rtl/sfx_prio_enc.sv - trigger priority encoder, bit 0 wins
module sfx_prio_enc
  import sfx_pkg::*;
(
  input  logic [2:0] trigger,
  output logic       hit,
  output logic [1:0] id
);

  // Lowest set bit selects the effect; id is 0 when nothing is requested
  always_comb begin
    hit = |trigger;
    id  = 2'd0;
    if (trigger[0])      id = 2'd0;
    else if (trigger[1]) id = 2'd1;
    else if (trigger[2]) id = 2'd2;
  end

endmodule

// File: rtl/sfx_sequencer.sv
// rtl/sfx_sequencer.sv - plays one of three sample ROMs, one sample per tick
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int LEN0 = LEN0_DEFAULT,
  parameter int LEN1 = LEN1_DEFAULT,
  parameter int LEN2 = LEN2_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        sample_tick,
  input  logic [2:0]  trigger,
  input  logic [7:0]  rom_data,
  output logic [18:0] read_address,
  output logic [1:0]  rom_sel,
  output logic [7:0]  sample_out,
  output logic        sample_valid,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  sfx_state_t        state, state_n;
  logic [18:0]       addr_n;
  sfx_id_t           sel_n;
  logic [7:0]        sout_n;
  logic              ovr_n;

  logic              trig_hit;
  logic [1:0]        trig_id;
  logic [18:0]       len_sel;
  logic              last_addr;
  logic              retrig;

  sfx_prio_enc u_prio_enc (
    .trigger (trigger),
    .hit     (trig_hit),
    .id      (trig_id)
  );

  // Length of the currently selected effect
  always_comb begin
    case (rom_sel)
      2'd0:    len_sel = 19'(LEN0);
      2'd1:    len_sel = 19'(LEN1);
      default: len_sel = 19'(LEN2);
    endcase
  end

  // Equal-or-higher priority request preempts the playing effect
  always_comb begin
    last_addr = (read_address == (len_sel - 19'd1));
    retrig    = trig_hit && (trig_id <= rom_sel);
  end

  // State register and datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= ST_IDLE;
      read_address <= '0;
      rom_sel      <= '0;
      sample_out   <= SILENCE;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      read_address <= addr_n;
      rom_sel      <= sel_n;
      sample_out   <= sout_n;
      overrun      <= ovr_n;
    end
  end

  // Next-state logic and per-cycle strobes
  always_comb begin
    state_n      = state;
    addr_n       = read_address;
    sel_n        = rom_sel;
    sout_n       = sample_out;
    ovr_n        = overrun;
    sample_valid = 1'b0;
    done         = 1'b0;
    busy         = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (trig_hit) begin
          sel_n   = trig_id;
          addr_n  = '0;
          state_n = ST_ARM;
        end
      end
      ST_ARM: begin
        if (retrig) begin
          sel_n   = trig_id;
          addr_n  = '0;
        end else if (sample_tick) begin
          state_n = ST_READ;
        end
      end
      ST_READ: begin
        // ROM output for the held address is valid now; capture it so it
        // is presented together with sample_valid in LATCH
        if (sample_tick) ovr_n = 1'b1;
        if (retrig) begin
          sel_n   = trig_id;
          addr_n  = '0;
          state_n = ST_ARM;
        end else begin
          sout_n  = rom_data;
          state_n = ST_LATCH;
        end
      end
      ST_LATCH: begin
        sample_valid = 1'b1;
        if (sample_tick) ovr_n = 1'b1;
        if (retrig) begin
          sel_n   = trig_id;
          addr_n  = '0;
          state_n = ST_ARM;
        end else if (last_addr) begin
          done    = 1'b1;
          busy    = 1'b0;
          sout_n  = SILENCE;
          state_n = ST_IDLE;
        end else begin
          addr_n  = read_address + 19'd1;
          state_n = ST_ARM;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Reset aborts playback without signalling completion
    if (Reset) done = 1'b0;
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// tb/tb_sfx_sequencer.sv - self-checking bench for sfx_sequencer
module tb_sfx_sequencer;

  localparam int L0 = 17646;
  localparam int L1 = 20;
  localparam int L2 = 600;

  logic        Clk;
  logic        Reset;
  logic        sample_tick;
  logic [2:0]  trigger;
  logic [7:0]  rom_data;
  logic [18:0] read_address;
  logic [1:0]  rom_sel;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        busy;
  logic        done;
  logic        overrun;

  int n_assert;
  int n_fail;
  int n_done;
  int n_valid;

  sfx_sequencer #(.LEN0(L0), .LEN1(L1), .LEN2(L2)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .sample_tick  (sample_tick),
    .trigger      (trigger),
    .rom_data     (rom_data),
    .read_address (read_address),
    .rom_sel      (rom_sel),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [7:0] rom_f(input logic [1:0] s, input logic [18:0] a);
    logic [31:0] v;
    v = 32'(a) * 32'd7 + 32'(s) * 32'd50 + 32'd3;
    return v[7:0];
  endfunction

  function automatic logic [18:0] tb_len(input logic [1:0] s);
    case (s)
      2'd0:    return 19'(L0);
      2'd1:    return 19'(L1);
      default: return 19'(L2);
    endcase
  endfunction

  // ROM model: one cycle of read latency
  always @(posedge Clk) rom_data <= rom_f(rom_sel, read_address);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] t, input logic k);
    Reset       = r;
    trigger     = t;
    sample_tick = k;
    #1;
  endtask

  task automatic next();
    @(negedge Clk);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_valid"}, sample_valid, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_sel"}, rom_sel, 0);
    chk({nm, "_addr"}, read_address, 0);
    chk({nm, "_sout"}, sample_out, 8'h80);
    chk({nm, "_ovr"}, overrun, 0);
  endtask

  // One sample period starting in ARM: tick, READ, LATCH
  task automatic play_one(input logic [1:0] es, input logic [18:0] ea, input logic [2:0] latch_trig);
    logic exp_done;
    exp_done = (ea == tb_len(es) - 19'd1) && (latch_trig == 3'b000);
    step(0, 3'b000, 1);
    chk("arm_addr", read_address, ea);
    chk("arm_sel", rom_sel, es);
    chk("arm_busy", busy, 1);
    chk("arm_done", done, 0);
    next();
    step(0, 3'b000, 0);
    chk("read_valid", sample_valid, 0);
    next();
    step(0, latch_trig, 0);
    chk("latch_valid", sample_valid, 1);
    chk("latch_sout", sample_out, rom_f(es, ea));
    chk("latch_done", done, exp_done);
    chk("latch_busy", busy, !exp_done);
    if (done) n_done++;
    if (sample_valid) n_valid++;
    next();
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  trig;
    logic        tick;
    logic        busy;
    logic        valid;
    logic        done;
    logic [1:0]  sel;
    logic [18:0] addr;
    logic [7:0]  sout;
    logic        ovr;
  } vec_t;

  vec_t vecs[11];

  initial begin
    n_assert = 0;
    n_fail   = 0;

    vecs[0]  = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 19'd0, 8'h80, 1'b0};
    vecs[1]  = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 19'd0, 8'h80, 1'b0};
    vecs[2]  = '{1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 19'd0, 8'h80, 1'b0};
    vecs[3]  = '{1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 19'd0, 8'h80, 1'b0};
    vecs[4]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 19'd0, 8'h80, 1'b0};
    vecs[5]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 19'd0, 8'h35, 1'b0};
    vecs[6]  = '{1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 19'd1, 8'h35, 1'b0};
    vecs[7]  = '{1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 19'd1, 8'h35, 1'b0};
    vecs[8]  = '{1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 19'd1, 8'h35, 1'b0};
    vecs[9]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 19'd1, 8'h3C, 1'b1};
    vecs[10] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 19'd2, 8'h3C, 1'b1};

    Reset = 1'b1; trigger = 3'b000; sample_tick = 1'b0;
    next(); next(); next();

    // Table: reset state, idle tick, priority pick, first samples, overrun
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].rst, vecs[i].trig, vecs[i].tick);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("v%0d_valid", i), sample_valid, vecs[i].valid);
      chk($sformatf("v%0d_done", i), done, vecs[i].done);
      chk($sformatf("v%0d_sel", i), rom_sel, vecs[i].sel);
      chk($sformatf("v%0d_addr", i), read_address, vecs[i].addr);
      chk($sformatf("v%0d_sout", i), sample_out, vecs[i].sout);
      chk($sformatf("v%0d_ovr", i), overrun, vecs[i].ovr);
      next();
    end

    // Overrun stays set until Reset
    for (int i = 0; i < 3; i++) begin
      step(0, 3'b000, 0);
      chk("ovr_sticky", overrun, 1);
      next();
    end
    step(1, 3'b000, 0); next();
    step(0, 3'b000, 0);
    chk_reset_state("rst1");

    // Effect 1: retrigger on final LATCH restarts without done
    next();
    step(0, 3'b010, 0); next();
    n_done = 0; n_valid = 0;
    for (int a = 0; a < L1; a++)
      play_one(2'd1, 19'(a), (a == L1 - 1) ? 3'b010 : 3'b000);
    chk("retrig_ndone", n_done, 0);
    step(0, 3'b000, 0);
    chk("retrig_addr", read_address, 0);
    chk("retrig_sel", rom_sel, 1);
    chk("retrig_busy", busy, 1);
    for (int a = 0; a < L1; a++)
      play_one(2'd1, 19'(a), 3'b000);
    step(0, 3'b000, 0);
    chk("e1_ndone", n_done, 1);
    chk("e1_silence", sample_out, 8'h80);
    chk("e1_idle_busy", busy, 0);
    chk("e1_idle_done", done, 0);
    next();

    // Effect 2 preempted at address 500 by effect 0; then effect 2 ignored
    step(0, 3'b100, 0); next();
    n_done = 0;
    for (int a = 0; a < 500; a++)
      play_one(2'd2, 19'(a), 3'b000);
    step(0, 3'b001, 0);
    chk("pre_addr", read_address, 500);
    chk("pre_done", done, 0);
    next();
    step(0, 3'b000, 0);
    chk("pre_sel", rom_sel, 0);
    chk("pre_addr0", read_address, 0);
    next();
    step(0, 3'b100, 0); next();
    step(0, 3'b000, 0);
    chk("low_ign_sel", rom_sel, 0);
    chk("low_ign_addr", read_address, 0);
    chk("pre_ndone", n_done, 0);

    // Effect 0 full length
    n_done = 0; n_valid = 0;
    for (int a = 0; a < L0; a++)
      play_one(2'd0, 19'(a), 3'b000);
    step(0, 3'b000, 0);
    chk("e0_nvalid", n_valid, L0);
    chk("e0_ndone", n_done, 1);
    chk("e0_silence", sample_out, 8'h80);
    chk("e0_busy", busy, 0);
    chk("e0_last_addr", read_address, L0 - 1);
    next();

    // Reset mid-playback with a simultaneous trigger
    step(0, 3'b001, 0); next();
    play_one(2'd0, 19'd0, 3'b000);
    step(0, 3'b000, 1); next();
    step(0, 3'b000, 0); next();
    step(1, 3'b001, 0);
    chk("rst_mid_done", done, 0);
    next();
    step(0, 3'b000, 0);
    chk_reset_state("rst2");
    next();
    step(0, 3'b000, 0);
    chk("rst2_stay_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
